// File: rtl/exu_wb_arbiter.sv
// Write-back arbiter: ALU results take the register-file port first, long-latency
// results are bypassed when the port is free or queued in order in a small FIFO.
`timescale 1ns/1ps
module exu_wb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we_i,
    input  logic [ADDR_W-1:0] alu_waddr_i,
    input  logic [DATA_W-1:0] alu_wdata_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    input  logic [ADDR_W-1:0] pend_raddr_i,
    output logic              pend_hit_o,
    output logic              busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

    wb_entry_t         fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

    logic alu_act;
    logic lsu_fire;
    logic lsu_nz;
    logic pop;
    logic bypass;
    logic push;

    assign lsu_ready_o = (count_q != CNT_W'(DEPTH));
    assign busy_o      = (count_q != '0);
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;

    // Output-slot arbitration and FIFO bookkeeping
    always_comb begin
        alu_act     = alu_we_i && (alu_waddr_i != '0);
        lsu_fire    = lsu_valid_i && lsu_ready_o;
        lsu_nz      = lsu_fire && (lsu_waddr_i != '0);
        pop         = !alu_act && (count_q != '0);
        bypass      = !alu_act && (count_q == '0) && lsu_nz;
        push        = lsu_nz && !bypass;

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        reg_we_d    = alu_act || pop || bypass;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;

        if (alu_act) begin
            reg_waddr_d = alu_waddr_i;
            reg_wdata_d = alu_wdata_i;
        end else if (pop) begin
            reg_waddr_d = fifo_q[rd_ptr_q].waddr;
            reg_wdata_d = fifo_q[rd_ptr_q].wdata;
        end else if (bypass) begin
            reg_waddr_d = lsu_waddr_i;
            reg_wdata_d = lsu_wdata_i;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
        end
    end

    // RAW lookup over the occupied window starting at the head
    always_comb begin
        logic [PTR_W-1:0] idx;
        pend_hit_o = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (fifo_q[idx].waddr == pend_raddr_i)) begin
                pend_hit_o = 1'b1;
            end
        end
        if (pend_raddr_i == '0) begin
            pend_hit_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Scoreboard bench for exu_wb_arbiter: a queue-based reference model predicts each
// register-file write; a separate monitor compares the DUT output every cycle.
`timescale 1ns/1ps
module tb_exu_wb_arbiter;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_we_i = 1'b0;
    logic [ADDR_W-1:0] alu_waddr_i = '0;
    logic [DATA_W-1:0] alu_wdata_i = '0;
    logic              lsu_valid_i = 1'b0;
    logic              lsu_ready_o;
    logic [ADDR_W-1:0] lsu_waddr_i = '0;
    logic [DATA_W-1:0] lsu_wdata_i = '0;
    logic              reg_we_o;
    logic [ADDR_W-1:0] reg_waddr_o;
    logic [DATA_W-1:0] reg_wdata_o;
    logic [ADDR_W-1:0] pend_raddr_i = '0;
    logic              pend_hit_o;
    logic              busy_o;

    exu_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .pend_raddr_i(pend_raddr_i), .pend_hit_o(pend_hit_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mq[$];
    logic [ADDR_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_d = '0;
    int                n_chk = 0;
    int                n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
    endtask

    // One stimulus cycle: check the combinational status against the model, drive
    // inputs, then predict the write that must appear after the next rising edge.
    task automatic cycle(input int unsigned aw, input int unsigned aa, input int unsigned ad,
                         input int unsigned lv, input int unsigned la, input int unsigned ld,
                         input int unsigned qa);
        wr_t e;
        wr_t l;
        bit  pend;
        bit  fire;
        bit  alu_act;
        bit  bypass;
        @(negedge clk);
        pend_raddr_i = ADDR_W'(qa);
        #1;
        pend = 1'b0;
        foreach (mq[i]) if (mq[i].a == ADDR_W'(qa) && qa != 0) pend = 1'b1;
        chk("lsu_ready", 64'(lsu_ready_o), 64'(mq.size() < DEPTH));
        chk("busy", 64'(busy_o), 64'(mq.size() != 0));
        chk("pend_hit", 64'(pend_hit_o), 64'(pend));

        alu_we_i    = aw[0];
        alu_waddr_i = ADDR_W'(aa);
        alu_wdata_i = DATA_W'(ad);
        lsu_valid_i = lv[0];
        lsu_waddr_i = ADDR_W'(la);
        lsu_wdata_i = DATA_W'(ld);

        fire    = lv[0] && (mq.size() < DEPTH);
        alu_act = aw[0] && (ADDR_W'(aa) != 0);
        bypass  = 1'b0;
        l.we = 1'b1; l.a = ADDR_W'(la); l.d = DATA_W'(ld);
        e.we = 1'b1;
        if (alu_act) begin
            e.a = ADDR_W'(aa); e.d = DATA_W'(ad);
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
        end else if (fire && l.a != 0) begin
            e = l; bypass = 1'b1;
        end else begin
            e.we = 1'b0; e.a = last_a; e.d = last_d;
        end
        if (fire && l.a != 0 && !bypass) mq.push_back(l);
        last_a = e.a;
        last_d = e.d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int unsigned n, input int unsigned qa);
        for (int i = 0; i < int'(n); i++) cycle(0, 0, 0, 0, 0, 0, qa);
    endtask

    // Asynchronous reset while the FIFO is full and a write is on the port
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_we", 64'(reg_we_o), 64'd0);
        chk("rst_waddr", 64'(reg_waddr_o), 64'd0);
        chk("rst_wdata", 64'(reg_wdata_o), 64'd0);
        chk("rst_ready", 64'(lsu_ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_pend", 64'(pend_hit_o), 64'd0);
        exp_q.delete();
        mq.delete();
        last_a = '0;
        last_d = '0;
        alu_we_i = 1'b0;
        lsu_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one prediction per cycle, compared just after the rising edge
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wb_we", 64'(reg_we_o), 64'(e.we));
                    chk("wb_waddr", 64'(reg_waddr_o), 64'(e.a));
                    chk("wb_wdata", 64'(reg_wdata_o), 64'(e.d));
                end else begin
                    chk("idle_we", 64'(reg_we_o), 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned alu_pct;
        int unsigned lsu_pct;
        #1;
        chk("reset_we", 64'(reg_we_o), 64'd0);
        chk("reset_waddr", 64'(reg_waddr_o), 64'd0);
        chk("reset_wdata", 64'(reg_wdata_o), 64'd0);
        chk("reset_ready", 64'(lsu_ready_o), 64'd1);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_pend", 64'(pend_hit_o), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ALU only, then an x0 write that must be dropped
        cycle(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        idle(1, 0);
        cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        idle(2, 0);

        // Bypass into an empty FIFO
        cycle(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 7);
        idle(2, 7);

        // Collision and ordering
        cycle(1, 1, 1, 1, 10, 32'hA, 10);
        cycle(1, 2, 2, 1, 11, 32'hB, 10);
        cycle(1, 3, 3, 0, 0, 0, 10);
        idle(4, 10);

        // Full with x12 held valid under back-pressure
        cycle(1, 4, 4, 1, 13, 32'hD, 12);
        cycle(1, 5, 5, 1, 14, 32'hE, 12);
        cycle(1, 6, 6, 1, 12, 32'hC, 12);
        cycle(1, 7, 7, 1, 12, 32'hC, 12);
        cycle(0, 0, 0, 1, 12, 32'hC, 12);
        cycle(0, 0, 0, 1, 12, 32'hC, 12);
        idle(3, 12);

        // Push and pop in the same cycle, wrapping the pointers
        cycle(1, 3, 33, 1, 20, 32'h20, 20);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 21 + i, 32'h100 + i, 20 + i);
        idle(3, 28);

        // Reset mid-operation with count=2 and a write on the port
        cycle(1, 1, 32'h51, 1, 21, 32'h21, 21);
        cycle(1, 2, 32'h52, 1, 22, 32'h22, 21);
        reset_mid();
        idle(4, 21);

        // Randomized traffic in phases of varying ALU pressure
        for (int p = 0; p < 30; p++) begin
            alu_pct = $urandom_range(10, 95);
            lsu_pct = $urandom_range(20, 90);
            for (int c = 0; c < 100; c++) begin
                cycle(($urandom_range(0, 99) < alu_pct) ? 1 : 0, $urandom_range(0, 7), $urandom,
                      ($urandom_range(0, 99) < lsu_pct) ? 1 : 0, $urandom_range(0, 15), $urandom,
                      $urandom_range(0, 15));
            end
        end

        idle(8, 0);
        @(posedge clk);
        #4;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exu_wb_arbiter.md
# exu_wb_arbiter

Write-back arbiter between the execute units and the integer register file write port. Each cycle it accepts the single-cycle ALU result, which always has priority and is never back-pressured, and it accepts results from the long-latency unit (load/mul-div) through a valid/ready handshake. Long-latency results that lose arbitration wait in a small in-order buffer. The block drives one registered write per cycle into the register file and exposes a pending-write lookup so decode can stall on read-after-write hazards.

## Interface
- DEPTH, 2, long-latency buffer entries (power of two, ≥2)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alu_we_i  in  1  ALU write request this cycle
- alu_waddr_i  in  ADDR_W  ALU destination register
- alu_wdata_i  in  DATA_W  ALU result
- lsu_valid_i  in  1  long-latency result valid
- lsu_ready_o  out  1  arbiter can accept a long-latency result
- lsu_waddr_i  in  ADDR_W  long-latency destination register
- lsu_wdata_i  in  DATA_W  long-latency result
- reg_we_o  out  1  register file write enable (registered)
- reg_waddr_o  out  ADDR_W  register file write address (registered)
- reg_wdata_o  out  DATA_W  register file write data (registered)
- pend_raddr_i  in  ADDR_W  register address queried by decode
- pend_hit_o  out  1  pend_raddr_i matches a buffered long-latency write
- busy_o  out  1  buffer non-empty

## Operation
- Buffer: circular FIFO with rd_ptr, wr_ptr, and count (0..DEPTH). Pointers wrap modulo DEPTH.
- lsu_ready_o = (count != DEPTH). It is combinational from registered state only and does not depend on lsu_valid_i.
- A long-latency fire occurs when lsu_valid_i && lsu_ready_o.
- alu_act = alu_we_i && alu_waddr_i != 0. Writes to x0 are dropped and do not occupy the output slot.
- Output-slot selection each cycle, in priority order:
  - 1: if alu_act, output the ALU write.
  - 2: else if count != 0, pop the FIFO head to the output.
  - 3: else if the fire carries a non-zero waddr, bypass it straight to the output without enqueuing.
  - 4: else reg_we_o <= 0.
- Enqueue: a fire with waddr != 0 that is not bypassed in case 3 is pushed at wr_ptr.
- A fire with waddr == 0 is accepted and discarded.
- Simultaneous push and pop leave count unchanged and advance both pointers. Push and pop never occur when count == DEPTH.
- When reg_we_o is 0, reg_waddr_o and reg_wdata_o hold their previous values.
- pend_hit_o is asserted when any occupied entry (count entries from rd_ptr) has waddr == pend_raddr_i. It is forced to 0 when pend_raddr_i == 0. It is purely combinational.
- busy_o = (count != 0).
- Long-latency results leave the block in acceptance order. Ordering against ALU writes to the same register is the issue logic's responsibility, using pend_hit_o.

## Timing
- Reset (async assert, deasserted synchronously to clk by the system):
  - reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - count=0, rd_ptr=0, wr_ptr=0.
  - Hence lsu_ready_o=1, busy_o=0, pend_hit_o=0.
- Latency: an ALU write accepted in cycle N appears on reg_we_o in cycle N+1.
- A bypassed long-latency write also appears in N+1.
- A buffered entry appears one cycle after the first cycle in which it is the FIFO head and alu_act=0.
- A FIFO entry stalls indefinitely under back-to-back ALU writes. lsu_ready_o drops once count reaches DEPTH.
- A push in cycle N is visible to pend_hit_o from cycle N+1.
- A pop in cycle N clears the hit from cycle N+1, which is the same cycle the write reaches the register file.
- Reset mid-operation discards all buffered entries and any in-flight output write.

## Test plan
- ALU only:
  - Stimulus: alu_we_i=1, waddr=5, wdata=0x1234_5678 in cycle 1.
  - Required: reg_we_o=1, waddr 5, data 0x12345678 in cycle 2; reg_we_o=0 in cycle 3.
  - x0 variant (waddr=0): reg_we_o stays 0.
- Bypass:
  - Stimulus: with the FIFO empty and no ALU request, lsu fire with waddr=7, data=0xDEAD_BEEF.
  - Required: written in the next cycle; count stays 0; lsu_ready_o stays 1.
- Collision and ordering:
  - Stimulus: ALU writes x1, x2, x3 on consecutive cycles, while lsu fires x10 (data 0xA) then x11 (data 0xB) in the first two cycles.
  - Required: the register file sees x1, x2, x3, x10, x11 in order.
  - Required: lsu_ready_o=0 after the second push (count=2).
  - Required: pend_hit_o=1 for query 10 until x10 is written.
- Full and back-pressure:
  - Stimulus: fill both entries while the ALU holds the slot; lsu_valid_i stays high with x12.
  - Required: x12 is not accepted until the first pop; ready rises in the cycle after the pop.
  - Required: no data is lost or duplicated.
- Push/pop same cycle:
  - Stimulus: count=1, alu idle, a new fire arrives.
  - Required: the head is written; the new entry is enqueued; count stays 1; pointers wrap correctly over 8 iterations.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously with count=2 and reg_we_o=1.
  - Required: all outputs go to 0 immediately (before the next clk edge); lsu_ready_o=1; no buffered write is emitted after reset release.
